adder_acc_n: RTL and testbench
==============================

Name: adder_acc_N

Overview:
- Sequential accumulator stage that consumes adder_N: its registered accumulator is fed back as P, incoming sample as Q, and it captures {Cout,SUM} every accepted sample.
- Sums a block of COUNT N-bit samples via valid/ready input handshake; presents the block total plus a sticky overflow flag on a valid/ready output handshake.
- Sits between a sample source (switches/ADC front end) and a display/consumer stage.

Parameters:
N, 3, data width of samples and accumulator (passed to adder_N)
COUNT, 4, samples per block; legal range 2..2**16

Ports:
CLK  input  1  rising-edge clock
n_RESET  input  1  synchronous active-low reset
CLR  input  1  synchronous clear of the current block, active high
IN_VALID  input  1  sample D/CIN valid
IN_READY  output  1  stage accepts a sample this cycle
D  input  N  sample to add
CIN  input  1  carry-in added with this sample
OUT_VALID  output  1  block result valid
OUT_READY  input  1  consumer accepts result
ACC  output  N  accumulator (running or final block total, mod 2**N)
OVF  output  1  sticky: any carry-out occurred during this block
CNT  output  $clog2(COUNT)+1  samples accepted in current block

Behaviour:
- Single clock domain; all state updates on rising CLK.
- Priority per edge: n_RESET low > CLR > handshake activity.
- Reset, sampled on edge with n_RESET=0: state=ACCUM, ACC=0, OVF=0, CNT=0, OUT_VALID=0. IN_READY=1 from the first cycle after reset release. Samples presented while n_RESET=0 are discarded.
- States: ACCUM, HOLD.
- ACCUM:
  - IN_READY=1, OUT_VALID=0.
  - Accept when IN_VALID && IN_READY.
  - On accept: adder_N(P=ACC, Q=D, Cin=CIN) gives an (N+1)-bit result. ACC <= SUM (wraps mod 2**N); OVF <= OVF | Cout; CNT <= CNT+1.
  - If accept and CNT==COUNT-1: go to HOLD next edge. In HOLD, CNT=COUNT and OUT_VALID=1.
  - No accept: all registers hold.
- HOLD:
  - IN_READY=0, OUT_VALID=1; ACC, OVF, CNT stable and IN_VALID ignored.
  - On OUT_VALID && OUT_READY: ACC=0, OVF=0, CNT=0, state=ACCUM next edge.
  - No same-cycle sample acceptance on the handoff edge (IN_READY was 0).
- Latency:
  - Accepted sample visible on ACC/OVF/CNT one cycle after the accepting edge.
  - OUT_VALID rises one cycle after the final accept.
  - Minimum block period is COUNT+1 cycles with OUT_READY tied high.
- CLR in either state: ACC=0, OVF=0, CNT=0, state=ACCUM, OUT_VALID=0. A sample presented in the CLR cycle is dropped. A pending HOLD result is discarded.
- OUT_VALID must not drop and ACC/OVF must not change while OUT_VALID=1 && OUT_READY=0, except by CLR or reset.
- IN_READY and OUT_VALID are decoded from registered state only; no combinational path from inputs.
- OVF is the carry-out of each step, not true-sum overflow. A wrap that later returns below 2**N still leaves OVF=1.

Test Plan:
Parameters N=3, COUNT=4. A bench integer model compares {OVF-any, ACC} against the integer sum mod 8 each block.

1. Reset, OUT_READY=1, D=1,2,3,1 (CIN=0) on consecutive cycles -> OUT_VALID=1 one cycle after 4th accept, ACC=7, OVF=0, CNT=4; next cycle ACC=0, CNT=0, IN_READY=1.
2. D=7,1,0,0 -> after 2nd accept ACC=0, OVF=1; final ACC=0, OVF=1.
3. D=0,0,0,0 with CIN=1 each -> ACC=4, OVF=0. Then D=7,7,7,7 CIN=1 -> ACC=(32 mod 8)=0, OVF=1.
4. Backpressure: complete a block with OUT_READY=0 for 5 cycles while IN_VALID=1, D=5 -> IN_READY=0 and ACC/OVF/CNT frozen for all 5 cycles. Raise OUT_READY -> next cycle ACC=0, IN_READY=1. The D=5 offered during HOLD is never accumulated.
5. After 2 accepts (ACC=3), assert CLR together with IN_VALID, D=4 -> ACC=0, CNT=0, sample dropped. Then assert CLR during HOLD -> OUT_VALID falls next cycle, result lost.
6. n_RESET low for 1 cycle mid-block (CNT=3, ACC=6) with IN_VALID=1 -> ACC=0, CNT=0, OVF=0, OUT_VALID=0. Then exhaustive sweep of all D in 0..7 and CIN in 0..1 with randomized IN_VALID/OUT_READY -> zero model mismatches.

Source files
------------

// File: rtl/adder_acc_n.sv
// adder_acc_n: block accumulator summing COUNT samples through adder_n, with a sticky carry flag and a valid/ready result handoff.
module adder_n #(
  parameter int N = 3
) (
  input  logic [N-1:0] P,
  input  logic [N-1:0] Q,
  input  logic         Cin,
  output logic [N:0]   S
);
  assign S = {1'b0, P} + {1'b0, Q} + {{N{1'b0}}, Cin};
endmodule

module adder_acc_n #(
  parameter int N     = 3,
  parameter int COUNT = 4,
  parameter int CW    = $clog2(COUNT) + 1
) (
  input  logic          CLK,
  input  logic          n_RESET,
  input  logic          CLR,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [N-1:0]  D,
  input  logic          CIN,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [N-1:0]  ACC,
  output logic          OVF,
  output logic [CW-1:0] CNT
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t        state_q;
  logic [N-1:0]  acc_q;
  logic          ovf_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    sum_d;
  adder_n #(.N(N)) u_add (.P(acc_q), .Q(D), .Cin(CIN), .S(sum_d));
  always_ff @(posedge CLK)
    if (!n_RESET || CLR) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == ACCUM) begin
      if (IN_VALID) begin
        acc_q <= sum_d[N-1:0];
        ovf_q <= ovf_q | sum_d[N];
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(COUNT - 1)) state_q <= HOLD;
      end
    end else if (OUT_READY) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end
  // handshake flags come straight from the state register, never from inputs
  assign IN_READY  = state_q == ACCUM;
  assign OUT_VALID = state_q == HOLD;
  assign ACC       = acc_q;
  assign OVF       = ovf_q;
  assign CNT       = cnt_q;
endmodule

// File: tb/tb_adder_acc_n.sv
// tb_adder_acc_n: scoreboard bench comparing block results and per-cycle outputs with an integer-sum model.
module tb_adder_acc_n;
  localparam int N = 3;
  localparam int COUNT = 4;
  localparam int CW = $clog2(COUNT) + 1;
  logic          CLK = 0;
  logic          n_RESET = 0;
  logic          CLR = 0;
  logic          IN_VALID = 0;
  logic          IN_READY;
  logic [N-1:0]  D = '0;
  logic          CIN = 0;
  logic          OUT_VALID;
  logic          OUT_READY = 0;
  logic [N-1:0]  ACC;
  logic          OVF;
  logic [CW-1:0] CNT;
  int checks = 0;
  int errors = 0;
  int m_tot = 0;
  int m_cnt = 0;
  bit m_hold = 0;
  int sb[$];
  adder_acc_n #(.N(N), .COUNT(COUNT)) dut (
    .CLK(CLK), .n_RESET(n_RESET), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D(D), .CIN(CIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ACC(ACC), .OVF(OVF), .CNT(CNT)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input bit iv, input int d, input bit cin, input bit ordy, input bit clr = 0, input bit rstn = 1);
    int e;
    @(negedge CLK);
    chk("in_ready", int'(IN_READY), int'(!m_hold));
    chk("out_valid", int'(OUT_VALID), int'(m_hold));
    chk("acc", int'(ACC), m_tot % 8);
    chk("ovf", int'(OVF), int'(m_tot >= 8));
    chk("cnt", int'(CNT), m_cnt);
    IN_VALID = iv;
    D = N'(d);
    CIN = cin;
    OUT_READY = ordy;
    CLR = clr;
    n_RESET = rstn;
    if (m_hold && ordy && rstn && !clr) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("block", int'({OVF, ACC}), e);
      end
    end
    @(posedge CLK);
    if (!rstn || clr) begin
      m_hold = 0; m_tot = 0; m_cnt = 0;
      sb.delete();
    end else if (!m_hold) begin
      if (iv) begin
        m_tot += d + int'(cin);
        m_cnt++;
        if (m_cnt == COUNT) begin
          m_hold = 1;
          sb.push_back(((m_tot >= 8) ? 8 : 0) + m_tot % 8);
        end
      end
    end else if (ordy) begin
      m_hold = 0; m_tot = 0; m_cnt = 0;
    end
  endtask
  initial begin
    bit done;
    bit iv;
    bit ordy;
    repeat (2) @(posedge CLK);
    tick(1, 5, 0, 1, 0, 0);
    tick(1, 1, 0, 1); tick(1, 2, 0, 1); tick(1, 3, 0, 1); tick(1, 1, 0, 1);
    tick(0, 0, 0, 1); tick(0, 0, 0, 1);
    tick(1, 7, 0, 1); tick(1, 1, 0, 1); tick(1, 0, 0, 1); tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 1);
    tick(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 7, 1, 1);
    tick(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, i + 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 5, 0, 0);
    tick(1, 5, 0, 1);
    tick(0, 0, 0, 1);
    tick(1, 1, 0, 1); tick(1, 2, 0, 1);
    tick(1, 4, 0, 1, 1);
    tick(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 6, 0, 0);
    tick(1, 1, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(1, 1, 0, 1); tick(1, 2, 0, 1); tick(1, 3, 0, 1);
    tick(1, 1, 0, 1, 0, 0);
    tick(0, 0, 0, 1);
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 2; c++) begin
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
          iv = 1'($urandom_range(0, 1));
          ordy = 1'($urandom_range(0, 1));
          done = iv && !m_hold;
          tick(iv, d, c[0], ordy);
        end
        if (!done) chk("sweep_timeout", 0, 1);
      end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
